// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - period/high-time checker with lock and stuck flags for a divided clock
module clk_div_monitor #(
    parameter int EXP_PERIOD = 7,
    parameter int EXP_HIGH   = 2,
    parameter int CNT_W      = 8,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sig,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_valid,
    output logic             o_err,
    output logic             o_lock,
    output logic             o_stuck
);

    localparam int GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  EXP_P    = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0]  EXP_H    = CNT_W'(EXP_HIGH);
    localparam logic [GOOD_W-1:0] LOCK_VAL = GOOD_W'(LOCK_CNT);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MEASURE = 1'b1;

    logic [0:0]        state;
    logic              sig_d;
    logic [CNT_W-1:0]  per_cnt;
    logic [CNT_W-1:0]  high_cnt;
    logic [GOOD_W-1:0] good_cnt;

    logic              rise;
    logic              mismatch;
    logic              at_timeout;
    logic [CNT_W-1:0]  per_inc;
    logic [CNT_W-1:0]  high_inc;
    logic [GOOD_W-1:0] good_next;

    // Edge detect and saturating next-count values
    always_comb begin
        rise       = i_sig & ~sig_d;
        at_timeout = (per_cnt == TO_VAL);
        mismatch   = (per_cnt != EXP_P) | (high_cnt != EXP_H);
        per_inc    = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_ONE;
        high_inc   = (high_cnt == CNT_MAX) ? high_cnt : high_cnt + CNT_ONE;
        good_next  = (good_cnt == LOCK_VAL) ? good_cnt : good_cnt + GOOD_W'(1);
    end

    // Measurement FSM: IDLE waits for a clean rise, MEASURE reports each full period
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            sig_d    <= 1'b1;
            per_cnt  <= '0;
            high_cnt <= '0;
            good_cnt <= '0;
            o_period <= '0;
            o_high   <= '0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
            o_lock   <= 1'b0;
            o_stuck  <= 1'b0;
        end else begin
            sig_d   <= i_sig;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        per_cnt  <= CNT_ONE;
                        high_cnt <= CNT_ONE;
                        o_stuck  <= 1'b0;
                        state    <= MEASURE;
                    end else begin
                        per_cnt <= per_inc;
                        if (at_timeout) begin
                            o_stuck <= 1'b1;
                        end
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        // The rise cycle opens the next period, so counts restart at 1
                        o_period <= per_cnt;
                        o_high   <= high_cnt;
                        o_valid  <= 1'b1;
                        per_cnt  <= CNT_ONE;
                        high_cnt <= CNT_ONE;
                        if (mismatch) begin
                            o_err    <= 1'b1;
                            good_cnt <= '0;
                            o_lock   <= 1'b0;
                        end else begin
                            good_cnt <= good_next;
                            if (good_next == LOCK_VAL) begin
                                o_lock <= 1'b1;
                            end
                        end
                    end else if (at_timeout) begin
                        o_stuck  <= 1'b1;
                        o_lock   <= 1'b0;
                        good_cnt <= '0;
                        per_cnt  <= '0;
                        state    <= IDLE;
                    end else begin
                        per_cnt <= per_inc;
                        if (i_sig) begin
                            high_cnt <= high_inc;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - self-checking bench for clk_div_monitor against a rise-timestamp model
module tb_clk_div_monitor;

    localparam int EXP_PERIOD = 7;
    localparam int EXP_HIGH   = 2;
    localparam int CNT_W      = 8;
    localparam int LOCK_CNT   = 4;
    localparam int TIMEOUT    = 64;
    localparam int VW         = 2 * CNT_W + 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sig = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic             valid;
    logic             err;
    logic             lock;
    logic             stuck;
    logic [VW-1:0]    dv;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk_div_monitor #(
        .EXP_PERIOD(EXP_PERIOD),
        .EXP_HIGH  (EXP_HIGH),
        .CNT_W     (CNT_W),
        .LOCK_CNT  (LOCK_CNT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_sig   (sig),
        .o_period(period),
        .o_high  (high),
        .o_valid (valid),
        .o_err   (err),
        .o_lock  (lock),
        .o_stuck (stuck)
    );

    assign dv = {period, high, valid, err, lock, stuck};

    // Reference model: timestamps of rises plus the sample history of the open period
    int         edge_n   = 0;
    bit         m_prev   = 1'b1;
    bit         m_meas   = 1'b0;
    int         m_rise_t = 0;
    int         m_origin = 0;
    int         m_run    = 0;
    bit         hist[$];
    logic [CNT_W-1:0] m_period = '0;
    logic [CNT_W-1:0] m_high   = '0;
    bit         m_valid  = 1'b0;
    bit         m_err    = 1'b0;
    bit         m_stuck  = 1'b0;

    function automatic void model(input bit s, input bit r);
        int ones;
        int el;
        edge_n++;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            m_prev   = 1'b1;
            m_meas   = 1'b0;
            m_origin = edge_n + 1;
            m_run    = 0;
            m_period = '0;
            m_high   = '0;
            m_stuck  = 1'b0;
            hist.delete();
            return;
        end
        el = edge_n - m_rise_t;
        if (s && !m_prev) begin
            if (m_meas) begin
                ones = 0;
                foreach (hist[i]) ones += int'(hist[i]);
                if (ones > 255) ones = 255;
                m_period = CNT_W'(el);
                m_high   = CNT_W'(ones);
                m_valid  = 1'b1;
                m_err    = (el != EXP_PERIOD) || (ones != EXP_HIGH);
                if (m_err) m_run = 0;
                else if (m_run < LOCK_CNT) m_run++;
            end
            m_meas   = 1'b1;
            m_rise_t = edge_n;
            m_stuck  = 1'b0;
            hist.delete();
            hist.push_back(s);
        end else if (m_meas) begin
            if (el == TIMEOUT) begin
                m_stuck  = 1'b1;
                m_run    = 0;
                m_meas   = 1'b0;
                m_origin = edge_n + 1;
            end else begin
                hist.push_back(s);
            end
        end else if (edge_n - m_origin == TIMEOUT) begin
            m_stuck = 1'b1;
        end
        m_prev = s;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_period, m_high, m_valid, m_err, (m_run == LOCK_CNT), m_stuck};
    endfunction

    task automatic step(input bit s, input bit r);
        sig = s;
        rst = r;
        @(posedge clk);
        model(s, r);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        if (dv !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", dv);
        end
        checks++;
        if (dv !== exp_vec()) begin
            failures++;
            $display("FAIL reset_model: got %h expected %h", dv, exp_vec());
        end
    endtask

    task automatic test_lock();
        int nvalid = 0;
        int rise_e = 0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int c = 0; c < 42; c++) begin
            step((c % 7) < 2, 1'b0);
            if (c == 0) rise_e = edge_n;
            checks++;
            if (dv !== exp_vec()) begin
                failures++;
                $display("FAIL lock_model c=%0d: got %h expected %h", c, dv, exp_vec());
            end
            if (valid) begin
                nvalid++;
                if (nvalid == 1) begin
                    checks++;
                    if ((edge_n - rise_e) != 7 || period !== 8'd7 || high !== 8'd2 || err !== 1'b0) begin
                        failures++;
                        $display("FAIL first_valid: got lat=%0d per=%0d high=%0d err=%b expected 7/7/2/0",
                                 edge_n - rise_e, period, high, err);
                    end
                end
                if (nvalid == 3 || nvalid == 4) begin
                    checks++;
                    if (lock !== (nvalid == 4)) begin
                        failures++;
                        $display("FAIL lock_at_valid n=%0d: got %b expected %b", nvalid, lock, nvalid == 4);
                    end
                end
            end
        end
    endtask

    task automatic test_stretch();
        int ngood = 0;
        bit seen_err = 1'b0;
        for (int c = 0; c < 43; c++) begin
            step((c < 8) ? (c < 2) : (((c - 8) % 7) < 2), 1'b0);
            checks++;
            if (dv !== exp_vec()) begin
                failures++;
                $display("FAIL stretch_model c=%0d: got %h expected %h", c, dv, exp_vec());
            end
            if (valid && period == 8'd8) begin
                seen_err = 1'b1;
                checks++;
                if (err !== 1'b1 || lock !== 1'b0) begin
                    failures++;
                    $display("FAIL stretch_err: got err=%b lock=%b expected 1/0", err, lock);
                end
            end else if (valid && seen_err) begin
                ngood++;
                if (ngood >= 3) begin
                    checks++;
                    if (lock !== (ngood >= 4)) begin
                        failures++;
                        $display("FAIL relock n=%0d: got %b expected %b", ngood, lock, ngood >= 4);
                    end
                end
            end
        end
        checks++;
        if (!seen_err || ngood != 4) begin
            failures++;
            $display("FAIL stretch_seen: got err_seen=%b good=%0d expected 1/4", seen_err, ngood);
        end
    endtask

    task automatic test_stuck();
        int r_e = 0;
        for (int c = 0; c < 80; c++) begin
            step(c < 2, 1'b0);
            if (c == 0) r_e = edge_n;
            checks++;
            if (dv !== exp_vec()) begin
                failures++;
                $display("FAIL stuck_model c=%0d: got %h expected %h", c, dv, exp_vec());
            end
            if (edge_n - r_e == 63 || edge_n - r_e == 64) begin
                checks++;
                if (stuck !== (edge_n - r_e == 64) || lock !== (edge_n - r_e == 63)) begin
                    failures++;
                    $display("FAIL stuck_time d=%0d: got stuck=%b lock=%b", edge_n - r_e, stuck, lock);
                end
            end
        end
        for (int c = 0; c < 21; c++) begin
            step((c % 7) < 2, 1'b0);
            checks++;
            if (dv !== exp_vec()) begin
                failures++;
                $display("FAIL resume_model c=%0d: got %h expected %h", c, dv, exp_vec());
            end
            if (c == 0) begin
                checks++;
                if (stuck !== 1'b0) begin
                    failures++;
                    $display("FAIL stuck_clear: got %b expected 0", stuck);
                end
            end
            if (c <= 7) begin
                checks++;
                if (valid !== (c == 7)) begin
                    failures++;
                    $display("FAIL resume_valid c=%0d: got %b expected %b", c, valid, c == 7);
                end
            end
        end
    endtask

    task automatic test_partial();
        step(1'b1, 1'b1);
        for (int c = 0; c < 28; c++) begin
            step((c < 3) ? 1'b1 : ((c < 7) ? 1'b0 : (((c - 7) % 7) < 2)), 1'b0);
            checks++;
            if (dv !== exp_vec()) begin
                failures++;
                $display("FAIL partial_model c=%0d: got %h expected %h", c, dv, exp_vec());
            end
            if (c <= 14) begin
                checks++;
                if (valid !== (c == 14) || (c == 14 && (period !== 8'd7 || high !== 8'd2 || err !== 1'b0))) begin
                    failures++;
                    $display("FAIL partial_valid c=%0d: got v=%b per=%0d high=%0d err=%b", c, valid, period, high, err);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int c = 0; c < 38; c++) begin
            step((c % 7) < 2, 1'b0);
            checks++;
            if (dv !== exp_vec()) begin
                failures++;
                $display("FAIL prereset_model c=%0d: got %h expected %h", c, dv, exp_vec());
            end
        end
        checks++;
        if (lock !== 1'b1) begin
            failures++;
            $display("FAIL prereset_lock: got %b expected 1", lock);
        end
        step(1'b0, 1'b1);
        checks++;
        if (dv !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got %h expected 0", dv);
        end
        step(1'b0, 1'b0);
        for (int c = 0; c < 21; c++) begin
            step((c % 7) < 2, 1'b0);
            checks++;
            if (dv !== exp_vec()) begin
                failures++;
                $display("FAIL postreset_model c=%0d: got %h expected %h", c, dv, exp_vec());
            end
            if (c <= 7) begin
                checks++;
                if (valid !== (c == 7)) begin
                    failures++;
                    $display("FAIL postreset_valid c=%0d: got %b expected %b", c, valid, c == 7);
                end
            end
        end
    endtask

    task automatic test_timeout_edge();
        for (int c = 0; c < 129; c++) begin
            step((c % 64) < 2, 1'b0);
            checks++;
            if (dv !== exp_vec() || stuck !== 1'b0) begin
                failures++;
                $display("FAIL edge_model c=%0d: got %h expected %h", c, dv, exp_vec());
            end
            if (c == 64) begin
                checks++;
                if (valid !== 1'b1 || period !== 8'd64 || err !== 1'b1) begin
                    failures++;
                    $display("FAIL edge_report: got v=%b per=%0d err=%b expected 1/64/1", valid, period, err);
                end
            end
        end
    endtask

    task automatic test_random();
        int p;
        int h;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                p = EXP_PERIOD;
                h = EXP_HIGH;
            end else begin
                p = $urandom_range(2, 72);
                h = $urandom_range(1, p - 1);
            end
            for (int c = 0; c < p; c++) begin
                step(c < h, $urandom_range(0, 199) == 0);
                checks++;
                if (dv !== exp_vec()) begin
                    failures++;
                    $display("FAIL random_model n=%0d p=%0d h=%0d c=%0d: got %h expected %h",
                             n, p, h, c, dv, exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_stretch();
        test_stuck();
        test_partial();
        test_mid_reset();
        test_timeout_edge();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
